conn50_cable_sched: RTL

- Round-robin scheduler and cycle sequencer for the shared 50-pin ribbon-cable link between the TUB and its peer crate.
- Serialises single-word read/write transactions from NREQ on-board requesters onto the cable's address/data/strobe/acknowledge lines.
- Sits between the local control logic and the cable connector pins.
- Owns the cable drive enable and the strobe/ack handshake, including the ack timeout.

---
 rtl/conn50_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/conn50_cable_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/conn50_pkg.sv
// Shared constants for the 50-pin cable scheduler: FSM encoding,
// strobe idle level, default cable widths and a saturating counter step.
package conn50_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

  localparam logic STB_IDLE = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_TURN    = 3'd4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after
// the pointer, wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    int tmp;
    logic [IW-1:0] k;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    tmp     = 0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      tmp = int'(ptr_i) + i;
      if (tmp >= NREQ) tmp = tmp - NREQ;
      k = IW'(tmp);
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/conn50_cable_sched.sv
// Round-robin scheduler and strobe/ack sequencer for the shared
// 50-pin ribbon cable between the TUB and its peer crate.
module conn50_cable_sched
  import conn50_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int SETUP_CYC = 2,
  parameter int TMO_CYC   = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  REQ_RW,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]  GNT,
  output logic [NREQ-1:0]  DONE,
  output logic             ERR,
  output logic [DW-1:0]    RDATA,
  output logic [AW-1:0]    CBL_ADDR,
  output logic [DW-1:0]    CBL_DOUT,
  output logic             CBL_OE,
  output logic             CBL_RW,
  output logic             CBL_STB_N,
  input  logic             CBL_ACK,
  input  logic [DW-1:0]    CBL_DIN
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TMO_CYC - 1);

  logic [2:0]      st_q, st_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            oe_q, oe_d;
  logic            rw_q, rw_d;
  logic            stb_n_q, stb_n_d;
  logic            err_q, err_d;
  logic            errp_q, errp_d;
  logic [1:0]      ack_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_vld)
  );

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    stb_n_d = stb_n_q;
    err_d   = err_q;
    done_d  = '0;
    errp_d  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        err_d = 1'b0;
        cnt_d = '0;
        if (arb_vld) begin
          gnt_d  = arb_gnt;
          idx_d  = arb_idx;
          addr_d = REQ_ADDR[arb_idx*AW +: AW];
          dout_d = REQ_WDATA[arb_idx*DW +: DW];
          rw_d   = REQ_RW[arb_idx];
          oe_d   = ~REQ_RW[arb_idx];
          st_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          stb_n_d = ~STB_IDLE;
          st_d    = ST_STROBE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_STROBE: begin
        // A stale-high ack on entry is accepted as a real ack.
        if (ack_q[1]) begin
          if (rw_q) rdata_d = CBL_DIN;
          cnt_d   = '0;
          stb_n_d = STB_IDLE;
          st_d    = ST_RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          stb_n_d = STB_IDLE;
          st_d    = ST_RELEASE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_RELEASE: begin
        if (!ack_q[1] || cnt_q == TMO_LAST) begin
          done_d = gnt_q;
          errp_d = err_q | ack_q[1];
          gnt_d  = '0;
          oe_d   = 1'b0;
          rw_d   = 1'b0;
          addr_d = '0;
          dout_d = '0;
          ptr_d  = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          st_d   = ST_TURN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_TURN: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      stb_n_q <= STB_IDLE;
      err_q   <= 1'b0;
      errp_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      stb_n_q <= stb_n_d;
      err_q   <= err_d;
      errp_q  <= errp_d;
      ack_q   <= {ack_q[0], CBL_ACK};
    end
  end

  assign GNT       = gnt_q;
  assign DONE      = done_q;
  assign ERR       = errp_q;
  assign RDATA     = rdata_q;
  assign CBL_ADDR  = addr_q;
  assign CBL_DOUT  = dout_q;
  assign CBL_OE    = oe_q;
  assign CBL_RW    = rw_q;
  assign CBL_STB_N = stb_n_q;

endmodule
